// File: rtl/bias_stream_ctrl_if.sv
// Handshake, bias ROM and output stream signals of bias_stream_ctrl.
// The slave modport is the controller side; the master modport is the
// environment side (start source, ROM, consumer FIFO).
interface bias_stream_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int KERN   = 64
);
    localparam int ADDR_W = (KERN > 1) ? $clog2(KERN) : 1;

    logic              ap_start;
    logic              ap_idle;
    logic              ap_done;
    logic [ADDR_W-1:0] bias_address;
    logic              bias_ce;
    logic [DATA_W-1:0] bias_q;
    logic [DATA_W-1:0] output_V_din;
    logic              output_V_full_n;
    logic              output_V_write;

    modport slave (
        input  ap_start, bias_q, output_V_full_n,
        output ap_idle, ap_done, bias_address, bias_ce, output_V_din, output_V_write
    );

    modport master (
        output ap_start, bias_q, output_V_full_n,
        input  ap_idle, ap_done, bias_address, bias_ce, output_V_din, output_V_write
    );
endinterface

// File: rtl/bias_stream_ctrl.sv
// Bias stream controller: sweeps the bias ROM REPS times per frame and
// streams every word, in order, into a consumer FIFO through a 2-entry
// skid buffer that absorbs the one-cycle ROM read latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for ap_start; ap_idle high
// S_RUN   | issuing ROM reads while the buffer has room
// S_DRAIN | all reads issued; emptying buffer and in-flight read
module bias_stream_ctrl #(
    parameter int DATA_W = 16,
    parameter int KERN   = 64,
    parameter int REPS   = 1024
) (
    input  logic ap_clk,
    input  logic ap_rst,
    bias_stream_ctrl_if.slave bus
);
    localparam int ADDR_W = (KERN > 1) ? $clog2(KERN) : 1;
    localparam int REP_W  = (REPS > 1) ? $clog2(REPS) : 1;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(KERN - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [REP_W-1:0]  rep;
    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        buf_count;
    logic              inflight;
    logic              done_q;

    logic              pop;
    logic              ce;
    logic              start_ok;
    logic              last_read;
    logic [1:0]        count_next;

    // Read-enable throttle, stream strobe and next buffer occupancy.
    // Outputs are also gated by ap_rst so an aborted frame emits nothing
    // in the reset cycle itself.
    always_comb begin
        pop        = (buf_count != 2'd0) && bus.output_V_full_n && !ap_rst;
        ce         = (state == S_RUN) && !ap_rst &&
                     (({1'b0, buf_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        count_next = buf_count + {1'b0, inflight} - {1'b0, pop};
        last_read  = ce && (addr == ADDR_LAST) && (rep == REP_LAST);
        // done_q blocks a start in the same cycle as the done pulse
        start_ok   = (state == S_IDLE) && bus.ap_start && !done_q;
    end

    // Frame sequencing; done pulses on the first IDLE cycle after a frame.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE:  if (start_ok) state <= S_RUN;
                S_RUN:   if (last_read) state <= S_DRAIN;
                S_DRAIN: begin
                    if (count_next == 2'd0 && !inflight) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Address/rep counters advance on every issued ROM read.
    always_ff @(posedge ap_clk) begin
        if (ap_rst || start_ok) begin
            addr <= '0;
            rep  <= '0;
        end else if (ce) begin
            if (addr == ADDR_LAST) begin
                addr <= '0;
                rep  <= (rep == REP_LAST) ? '0 : rep + 1'b1;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

    // Two-entry buffer: capture ROM data one cycle after the read, pop on write.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            buf_count <= 2'd0;
            inflight  <= 1'b0;
        end else begin
            inflight <= ce;
            if (inflight) begin
                mem[wr_ptr] <= bus.bias_q;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            buf_count <= count_next;
        end
    end

    assign bus.ap_idle        = (state == S_IDLE);
    assign bus.ap_done        = done_q && !ap_rst;
    assign bus.bias_address   = addr;
    assign bus.bias_ce        = ce;
    assign bus.output_V_write = pop;
    assign bus.output_V_din   = mem[rd_ptr];

endmodule

// File: doc/bias_stream_ctrl.md
BIAS_STREAM_CTRL -- requirements
Module: bias_stream_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: bias word width, equal to the coefficient width.
REQ-002 Parameter KERN, default 64: number of bias words in the ROM, one per output channel.
REQ-003 Parameter REPS, default 1024: number of full bias sweeps per frame.
REQ-004 Derived ADDR_W = max(1, clog2(KERN)); not user-set.
REQ-005 ap_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 ap_rst  in  1  synchronous, active-high reset.
REQ-007 ap_start  in  1  one-cycle start request; sampled only in IDLE.
REQ-008 ap_idle  out  1  high while in IDLE.
REQ-009 ap_done  out  1  one-cycle pulse after the last word of the frame is written.
REQ-010 bias_address  out  ADDR_W  ROM read address.
REQ-011 bias_ce  out  1  ROM read enable.
REQ-012 bias_q  in  DATA_W  ROM data, valid the cycle after bias_ce is high.
REQ-013 output_V_din  out  DATA_W  stream data toward the consumer FIFO.
REQ-014 output_V_full_n  in  1  consumer FIFO not full.
REQ-015 output_V_write  out  1  stream write strobe.

Function
REQ-016 States SHALL be IDLE, RUN and DRAIN. Transitions: IDLE->RUN on ap_start; RUN->DRAIN when the last ROM read (rep REPS-1, addr KERN-1) is issued; DRAIN->IDLE when the buffer is empty and no read is in flight.
REQ-017 The address counter SHALL run 0..KERN-1 and wrap to 0; each wrap increments the rep counter 0..REPS-1.
REQ-018 bias_ce SHALL be high only in RUN, and only when (buf_count + inflight - pop) < 2. Here pop = output_V_write in the same cycle.
REQ-019 Read data SHALL be captured into a 2-entry FIFO buffer at the end of the cycle after bias_ce was high; inflight is at most 1.
REQ-020 output_V_write SHALL equal (buf_count > 0) AND output_V_full_n; output_V_din SHALL be the buffer head, held stable while not written.
REQ-021 Data SHALL not be written when full_n is low; stalls of any length SHALL lose, duplicate and reorder no word.
REQ-022 Emitted order: bias[0..KERN-1], repeated REPS times. Total writes per frame = KERN*REPS exactly.
REQ-023 With full_n continuously high, throughput SHALL be 1 word/cycle after fill.
REQ-024 Latency: ap_start high in cycle T -> bias_ce/address 0 in T+1 -> first output_V_write in T+3.
REQ-025 ap_done SHALL pulse in the cycle the FSM returns to IDLE; ap_idle SHALL rise in that same cycle.
REQ-026 ap_start while RUN/DRAIN SHALL be ignored, not queued.
REQ-027 ap_start in the same cycle as ap_done SHALL be ignored; a new frame needs ap_start while ap_idle is high.
REQ-028 KERN=1 and REPS=1 SHALL be legal; the frame then emits one word.
REQ-029 Simultaneous capture and pop in the same cycle SHALL leave buf_count unchanged.

Reset
REQ-030 While ap_rst is high at a clock edge, the block SHALL enter IDLE on that edge.
REQ-031 On that edge, counters, buffer and inflight SHALL clear.
REQ-032 Reset output values: ap_idle=1, ap_done=0, bias_ce=0, output_V_write=0, bias_address=0, output_V_din=0.
REQ-033 Reset mid-frame SHALL abort with no further writes; no ap_done SHALL be issued for the aborted frame.
REQ-034 ROM data returning after reset SHALL be discarded.
REQ-035 ap_start SHALL be ignored while ap_rst is high.

Verification
REQ-036 KERN=4, REPS=2, full_n=1, ROM={10,11,12,13}, start at T -> writes T+3..T+10 carry 10,11,12,13,10,11,12,13; ap_done at T+11.
REQ-037 Same setup, full_n=0 during cycles T+4..T+8 -> no write while low; sequence unchanged; bias_ce never drives buffer above 2 entries.
REQ-038 full_n toggling randomly at 50% over 1000 frames -> scoreboard matches KERN*REPS words in order, one ap_done per frame.
REQ-039 ap_rst asserted for 1 cycle after the 5th write -> next cycle write=0, ce=0, ap_idle=1; later start emits from bias[0] rep 0.
REQ-040 ap_start pulsed during RUN and on the ap_done cycle -> ignored; exactly one frame emitted.
REQ-041 KERN=1, REPS=1 -> single write of bias[0] at T+3; ap_done at T+4.
